datamem_sized: RTL

//  Parametrised MIPS data memory with byte, halfword and word access.

---
 rtl/datamem_sized.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/datamem_sized.sv
// MIPS data memory: byte/half/word loads and stores behind a req/ready handshake
// with programmable wait states; faulted requests complete with no side effects.
module datamem_sized #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [DEPTH];

  logic          commit, bad, misalign, oor, we;
  logic [AW-1:0] idx;
  logic [4:0]    lane_sh;
  logic [31:0]   word, shifted, load_val, wmask, wval, new_word;

  assign idx     = addr_q[AW+1:2];
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign word    = mem[idx];
  assign shifted = word >> lane_sh;

  assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign oor      = |(addr_q >> (AW + 2));
  assign bad      = (size_q == 2'b11) || (rd_q == wr_q) || misalign || oor;
  assign commit   = (state_q == BUSY) && (cnt_q == '0);
  assign we       = commit && !bad && wr_q && rst_n;

  // Halves are aligned whenever they commit, so the byte-lane shift also selects the half.
  always_comb begin
    load_val = shifted;
    wmask    = '1;
    wval     = wdata_q;
    case (size_q)
      2'b00: begin
        load_val = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        wmask    = 32'h0000_00FF << lane_sh;
        wval     = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_val = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        wmask    = 32'h0000_FFFF << lane_sh;
        wval     = {2{wdata_q[15:0]}};
      end
      default: begin
        load_val = word;
        wmask    = '1;
        wval     = wdata_q;
      end
    endcase
    new_word = (word & ~wmask) | (wval & wmask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = address;
          wdata_d = write_data;
          size_d  = size;
          uns_d   = unsigned_ld;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          cnt_d   = 4'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
          fault_d = bad;
          if (!bad && rd_q) rdata_d = load_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= new_word;
  end

  assign read_data = rdata_q;
  assign ready     = ready_q;
  assign fault     = fault_q;

endmodule
